seg_display_scan: RTL and testbench

- Drives an 8-digit, common-anode seven-segment display from the 32-bit packed BCD digit bus and the commit flag produced by the keypad/button entry block.
- A rising edge on the commit flag captures the digit bus into a shadow register.
- The block time-multiplexes the eight digits with a programmable refresh divider and a ghost-suppression blanking window.
- Sits between the button-entry logic and the board's AN/SEG/DP pins.

---
 rtl/seg_display_scan.sv | 156 +++++++++++++++
 tb/tb_seg_display_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
//   Scans an 8-digit common-anode seven-segment display. The BCD digit bus is
//   captured into a shadow register on each rising edge of the commit flag.
//   Digits are then time-multiplexed one slot at a time. Each slot opens with
//   a short all-anodes-off window that suppresses ghosting between digits.
//
// Optional feature:
//   SEG_LZB_EN - leading-zero blanking for the digits left of DP_POS.
//
// Parameters:
//   REFRESH_DIV - clock cycles per digit slot (>= 4)
//   BLANK_CYC   - cycles at the start of each slot with all anodes off (< REFRESH_DIV)
//   DP_POS      - digit whose decimal point is lit; 8 disables the point
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   data_i   in   packed digits, digit k = data_i[4k+3:4k], digit 7 leftmost
//   load_i   in   commit flag (debounced level), rising edge captures data_i
//   loaded_o out  one-cycle pulse the cycle after a capture
//   an_o     out  anode enables, active-low, bit k = digit k
//   seg_o    out  segments {g,f,e,d,c,b,a}, active-low
//   dp_o     out  decimal point, active-low
// -----------------------------------------------------------------------------
module seg_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int DP_POS      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        load_i,
  output logic        loaded_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  typedef enum logic {
    SLOT_BLANK,
    SLOT_DRIVE
  } slot_e;

  // Active-high gfedcba pattern; non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

`ifdef SEG_LZB_EN
  // Digit k is a leading zero when digits 7..k are all zero. Digit 0 and the
  // digits at or right of the decimal point always show.
  function automatic logic lzb_blank(input logic [31:0] d, input logic [2:0] k);
    logic all_zero;
    logic exempt;
    all_zero = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if ((j >= int'(k)) && (d[4*j +: 4] != 4'h0)) all_zero = 1'b0;
    end
    exempt = (k == 3'd0) || ((DP_POS < 8) && (int'(k) <= DP_POS));
    return all_zero && !exempt;
  endfunction
`endif

  logic        load_q;
  logic [31:0] disp_q, disp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        loaded_q, loaded_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  slot_e       slot;
  logic        capture;
  logic        wrap;
  logic        blank_digit;
  logic [3:0]  nib;

  always_comb begin
    capture     = load_i & ~load_q;
    wrap        = (cnt_q == CNT_LAST);
    slot        = (cnt_q < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;
    nib         = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    blank_digit = lzb_blank(disp_q, idx_q);
`else
    blank_digit = 1'b0;
`endif

    disp_d   = capture ? data_i : disp_q;
    loaded_d = capture;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = wrap ? idx_q + 3'd1 : idx_q;

    // Segments and point stay dark whenever no anode is on.
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (slot == SLOT_DRIVE) begin
      an_d = ~(8'h01 << idx_q);
      if (!blank_digit) begin
        seg_d = ~seg_decode(nib);
        dp_d  = !((DP_POS < 8) && (int'(idx_q) == DP_POS));
      end
    end
  end

  // load_q resets high so a flag already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q   <= 1'b1;
      disp_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      load_q   <= load_i;
      disp_q   <= disp_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign loaded_o = loaded_q;
  assign an_o     = an_q;
  assign seg_o    = seg_q;
  assign dp_o     = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scan
//   Directed bench for seg_display_scan with REFRESH_DIV=8, BLANK_CYC=2,
//   DP_POS=2. The scan phase is tracked by counting clock edges since reset
//   release: the outputs sampled after edge n reflect cnt=(n-1)%8 and
//   idx=((n-1)/8)%8.
// -----------------------------------------------------------------------------
module tb_seg_display_scan;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_i;
  logic        load_i;
  logic        loaded_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int checks;
  int failures;
  int n;

  // Active-low segment patterns for digits 0..9.
  logic [6:0] lo [10];

  seg_display_scan #(
    .REFRESH_DIV(8),
    .BLANK_CYC  (2),
    .DP_POS     (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .load_i  (load_i),
    .loaded_o(loaded_o),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Advance until the sampled outputs correspond to slot k, prescaler value c.
  task automatic goto(input int k, input int c);
    for (int i = 0; i < 80; i++) begin
      if ((n >= 1) && (((n - 1) % 8) == c) && ((((n - 1) / 8) % 8) == k)) return;
      tick();
    end
  endtask

  initial begin
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    int         pulses;
    int         waited;

    lo[0] = 7'h40; lo[1] = 7'h79; lo[2] = 7'h24; lo[3] = 7'h30; lo[4] = 7'h19;
    lo[5] = 7'h12; lo[6] = 7'h02; lo[7] = 7'h78; lo[8] = 7'h00; lo[9] = 7'h10;

    checks   = 0;
    failures = 0;
    n        = 0;
    rst_n    = 1'b0;
    load_i   = 1'b0;
    data_i   = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_an",     32'(an_o),     32'hFF);
    check("rst_seg",    32'(seg_o),    32'h7F);
    check("rst_dp",     32'(dp_o),     32'h1);
    check("rst_loaded", 32'(loaded_o), 32'h0);

    // Release: two blank cycles, first anode on the third edge
    rst_n = 1'b1;
    n     = 0;
    tick();
    check("rel_c1_an", 32'(an_o), 32'hFF);
    tick();
    check("rel_c2_an", 32'(an_o), 32'hFF);
    tick();
    check("rel_c3_an",  32'(an_o),  32'hFE);
    check("rel_c3_seg", 32'(seg_o), 32'h40);
    check("rel_c3_dp",  32'(dp_o),  32'h1);

    // Asynchronous reset in the middle of a drive phase
    tick();
    tick();
    check("middrive_an", 32'(an_o), 32'hFE);
    rst_n = 1'b0;
    #1;
    check("async_rst_an",  32'(an_o),  32'hFF);
    check("async_rst_seg", 32'(seg_o), 32'h7F);
    check("async_rst_dp",  32'(dp_o),  32'h1);

    // Flag held high across reset release must not capture
    load_i = 1'b1;
    data_i = 32'h1111_1119;
    tick();
    rst_n = 1'b1;
    n     = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_rst_loaded", 32'(loaded_o), 32'h0);
    end
    check("held_rst_an",  32'(an_o),  32'hFE);
    check("held_rst_seg", 32'(seg_o), 32'h40);
    load_i = 1'b0;
    tick();

    // Capture 1234_5678
    data_i = 32'h1234_5678;
    load_i = 1'b1;
    tick();
    check("cap_loaded_hi", 32'(loaded_o), 32'h1);
    tick();
    check("cap_loaded_lo", 32'(loaded_o), 32'h0);
    load_i = 1'b0;

    for (int k = 0; k < 8; k++) begin
      exp_an = ~(8'h01 << k);
      goto(k, 1);
      check("blank_an",  32'(an_o),  32'hFF);
      check("blank_seg", 32'(seg_o), 32'h7F);
      check("blank_dp",  32'(dp_o),  32'h1);
      goto(k, 2);
      check("drive_an", 32'(an_o), 32'(exp_an));
      goto(k, 4);
      check("scan_an",  32'(an_o),  32'(exp_an));
      check("scan_seg", 32'(seg_o), 32'(lo[8 - k]));
      check("scan_dp",  32'(dp_o),  (k == 2) ? 32'h0 : 32'h1);
    end

    // Index wraps from 7 back to 0: digit 0 anode returns 6 edges after (7,4)
    waited = 0;
    for (int i = 0; i < 70; i++) begin
      if (an_o == 8'hFE) break;
      tick();
      waited++;
    end
    check("wrap_delay", 32'(waited), 32'd6);
    check("wrap_seg",   32'(seg_o),  32'(lo[8]));

    // Held flag with changing data: one capture, one pulse
    goto(3, 0);
    data_i = 32'h0000_00A0;
    load_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (loaded_o) pulses++;
      data_i = $urandom;
    end
    check("held_pulses", 32'(pulses), 32'd1);
    load_i = 1'b0;
    tick();
    goto(1, 4);
    check("dash_an",  32'(an_o),  32'hFD);
    check("dash_seg", 32'(seg_o), 32'h3F);

    // Capture to visible: two edges after the capture edge
    goto(0, 2);
    data_i = 32'h0000_0005;
    load_i = 1'b1;
    tick();
    check("c2v_loaded", 32'(loaded_o), 32'h1);
    check("c2v_old",    32'(seg_o),    32'h40);
    tick();
    check("c2v_new",    32'(seg_o),    32'h12);
    load_i = 1'b0;

    for (int k = 1; k < 8; k++) begin
      exp_an = ~(8'h01 << k);
`ifdef SEG_LZB_EN
      exp_seg = (k >= 3) ? 7'h7F : 7'h40;
`else
      exp_seg = 7'h40;
`endif
      goto(k, 4);
      check("lzb_an",  32'(an_o),  32'(exp_an));
      check("lzb_seg", 32'(seg_o), 32'(exp_seg));
      check("lzb_dp",  32'(dp_o),  (k == 2) ? 32'h0 : 32'h1);
    end
    goto(0, 4);
    check("lzb_d0_seg", 32'(seg_o), 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
